// File: rtl/i2s_pkg.sv
// Shared timing constants for the I2S transmitter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package i2s_pkg;

    localparam int CNT_W    = 11;               // frame counter width (2048 clk per frame)
    localparam int SLOT_W   = 32;               // bit clocks per lrck half
    localparam int MCLK_BIT = 2;                // cnt bit giving clk/8
    localparam int SCLK_BIT = 4;                // cnt bit giving clk/32
    localparam int LRCK_BIT = 10;               // cnt bit giving clk/2048
    localparam int POS_W    = $clog2(SLOT_W);   // width of slot bit position

endpackage

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry pending buffer feeding a fixed-rate stereo serializer.
// Latency: a pair accepted in frame N starts on sdata at cnt=32 of frame N+1.
// Backpressure: s_ready drops while the pending pair waits for the next frame-load edge.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   s_valid/s_ready     sample-pair handshake; s_left/s_right two's complement samples
//   mclk, sclk, lrck    registered clock outputs (clk/8, clk/32, clk/2048); lrck=0 is left
//   sdata               serial data, MSB first after a one-bit delay in each slot
//   underrun            one-cycle pulse when a frame starts with nothing pending
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              mclk,
    output logic              sclk,
    output logic              lrck,
    output logic              sdata,
    output logic              underrun
);

    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mclk_q, sclk_q, lrck_q;
    logic              sdata_q, sdata_d;
    logic              underrun_q, underrun_d;
    logic              pend_full_q, pend_full_d;
    logic [DATA_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;

    logic              frame_edge;   // cnt wraps 2047 -> 0
    logic              bit_edge;     // cnt[4:0] wraps 31 -> 0
    logic              xfer;
    logic [POS_W-1:0]  pos_d;        // slot bit position that starts after this edge
    logic              slot_d;       // 0 = left slot, 1 = right slot after this edge
    logic [DATA_W-1:0] sel;

    assign cnt_d      = cnt_q + CNT_W'(1);
    assign frame_edge = &cnt_q;
    assign bit_edge   = &cnt_q[SCLK_BIT:0];
    assign pos_d      = cnt_d[LRCK_BIT-1:SCLK_BIT+1];
    assign slot_d     = cnt_d[LRCK_BIT];
    assign sel        = slot_d ? hold_r_q : hold_l_q;

    // Gated with rst so the block never advertises space while held in reset.
    assign s_ready    = ~pend_full_q & ~rst;
    assign xfer       = s_valid & s_ready;

    always_comb begin
        pend_full_d = pend_full_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        underrun_d  = 1'b0;
        sdata_d     = sdata_q;

        // Position 0 is the I2S delay bit; positions 1..DATA_W walk the sample
        // MSB first. Shifting left by pos-1 puts the wanted bit at the MSB, and
        // positions past DATA_W shift everything out, giving the trailing zeros.
        if (bit_edge) begin
            sdata_d = (pos_d != '0) &&
                      (((sel << (pos_d - POS_W'(1))) & MSB_MASK) != '0);
        end

        // At the frame edge the next bit is the delay bit, so reloading hold
        // here never disturbs a bit being shifted out.
        if (frame_edge) begin
            if (pend_full_q) begin
                hold_l_d    = pend_l_q;
                hold_r_d    = pend_r_q;
                pend_full_d = 1'b0;
            end else begin
                hold_l_d   = '0;
                hold_r_d   = '0;
                underrun_d = 1'b1;
            end
        end

        // xfer implies pending was empty, so it never races the move above;
        // a pair arriving on the load edge waits a full frame (no bypass).
        if (xfer) begin
            pend_l_d    = s_left;
            pend_r_d    = s_right;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mclk_q      <= 1'b0;
            sclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            pend_full_q <= 1'b0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            mclk_q      <= cnt_q[MCLK_BIT];
            sclk_q      <= cnt_q[SCLK_BIT];
            lrck_q      <= cnt_q[LRCK_BIT];
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            pend_full_q <= pend_full_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
        end
    end

    assign mclk     = mclk_q;
    assign sclk     = sclk_q;
    assign lrck     = lrck_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule
